key_load_reg: RTL

//  Parametrised key register: KEY_W bits arrive one per accepted cycle, with an optional even-parity check.

---
 rtl/key_load_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/key_load_reg.sv
// key_load_reg
//   Serial-load key register for locked netlists. KEY_W key bits arrive one
//   per accepted cycle, optionally followed by one even-parity bit. key_out
//   stays all-zero (netlist locked) until a complete, parity-clean key has
//   been committed.
//
// Ports
//   C          in   1      clock, rising edge
//   R          in   1      asynchronous reset, active-high
//   start      in   1      begin/restart a key load (wins over bit_vld)
//   bit_in     in   1      serial key bit
//   bit_vld    in   1      bit_in valid this cycle
//   key_out    out  KEY_W  committed key, zero when not ready
//   key_ready  out  1      key_out holds a valid key
//   key_err    out  1      last load failed parity, sticky until start/R
//   busy       out  1      load in progress (SHIFT or CHECK)
//   bit_cnt    out  CW     bits accepted in the current load
module key_load_reg #(
  parameter int KEY_W     = 64,
  parameter int PARITY_EN = 1,
  parameter int LSB_FIRST = 1,
  localparam int CW       = $clog2(KEY_W + PARITY_EN + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ready,
  output logic             key_err,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt
);

  localparam int N = KEY_W + PARITY_EN;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] KEY_CNT  = CW'(KEY_W);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, READY} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [KEY_W-1:0] shift_reg;
  logic             par_acc;
  logic             par_ok;
  logic             last_bit;

  // Insert one received bit so that the first bit of the load ends up at
  // key_out[0] (LSB_FIRST=1) or key_out[KEY_W-1] (LSB_FIRST=0) after KEY_W bits.
  function automatic logic [KEY_W-1:0] shift_in(input logic [KEY_W-1:0] sr,
                                                input logic b);
    if (LSB_FIRST != 0) shift_in = {b, sr[KEY_W-1:1]};
    else                shift_in = {sr[KEY_W-2:0], b};
  endfunction

  // Running XOR covers key and parity bits, so even parity leaves it at 0.
  assign par_ok   = (PARITY_EN == 0) ? 1'b1 : ~par_acc;
  assign last_bit = bit_vld && (bit_cnt == LAST_CNT);

  always_ff @(posedge C or posedge R) begin
    if (R) state_q <= IDLE;
    else   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SHIFT;
    end else begin
      case (state_q)
        SHIFT:   if (last_bit) state_d = CHECK;
        CHECK:   state_d = par_ok ? READY : IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == SHIFT) || (state_q == CHECK);
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      shift_reg <= '0;
      par_acc   <= 1'b0;
      bit_cnt   <= '0;
      key_out   <= '0;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
    end else if (start) begin
      shift_reg <= '0;
      par_acc   <= 1'b0;
      bit_cnt   <= '0;
      key_out   <= '0;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_vld) begin
            bit_cnt <= bit_cnt + CW'(1);
            par_acc <= par_acc ^ bit_in;
            // The trailing parity bit never enters the key register.
            if (bit_cnt < KEY_CNT) shift_reg <= shift_in(shift_reg, bit_in);
          end
        end
        CHECK: begin
          if (par_ok) begin
            key_out   <= shift_reg;
            key_ready <= 1'b1;
          end else begin
            key_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
